// File: rtl/button_bank_if.sv
// button_bank_if: key pins and debounced/pulse outputs of button_bank. N = channel count.
// Ports: key (raw pins), state (debounced level), press_pulse, depress_pulse, long_pulse, repeat_pulse.
interface button_bank_if #(parameter int N = 4);
  logic [N-1:0] key;
  logic [N-1:0] state;
  logic [N-1:0] press_pulse;
  logic [N-1:0] depress_pulse;
  logic [N-1:0] long_pulse;
  logic [N-1:0] repeat_pulse;
  modport master (output key, input state, press_pulse, depress_pulse, long_pulse, repeat_pulse);
  modport slave (input key, output state, press_pulse, depress_pulse, long_pulse, repeat_pulse);
endinterface

// File: rtl/button_bank.sv
// button_bank: N-channel key synchroniser, debouncer, edge and long-press detector; clk, rst (sync active-high), bus (button_bank_if.slave); BUTTON_AUTOREPEAT_EN enables repeat_pulse.
module button_bank #(
  parameter int N = 4,
  parameter int ACTIVE_LOW = 0,
  parameter int DB_CYCLES = 131072,
  parameter int LONG_CYCLES = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input logic clk,
  input logic rst,
  button_bank_if.slave bus
);
  localparam int DW = $clog2(DB_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HC_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HC_PRE = HW'(LONG_CYCLES - 1);
  localparam logic [N-1:0] REL = (ACTIVE_LOW != 0) ? '1 : '0;
  logic [N-1:0] s1, s2, s3, ks, state, state_n, prev, lp, rp;
  logic [DW-1:0] dbc [N];
  logic [DW-1:0] dbc_n [N];
  logic [HW-1:0] hc [N];
  assign ks = s3 ^ REL;
  always_comb begin
    state_n = state;
    dbc_n = dbc;
    for (int i = 0; i < N; i++) begin
      dbc_n[i] = (ks[i] == state[i] || dbc[i] == DB_MAX) ? '0 : dbc[i] + 1'b1;
      state_n[i] = (ks[i] != state[i] && dbc[i] == DB_MAX) ? ~state[i] : state[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s3, s2, s1} <= {3{REL}};
      state <= '0;
      prev <= '0;
      lp <= '0;
      for (int i = 0; i < N; i++) begin
        dbc[i] <= '0;
        hc[i] <= '0;
      end
    end else begin
      {s3, s2, s1} <= {s2, s1, bus.key};
      state <= state_n;
      prev <= state;
      dbc <= dbc_n;
      for (int i = 0; i < N; i++) begin
        hc[i] <= (state[i] && state_n[i]) ? ((hc[i] == HC_MAX) ? hc[i] : hc[i] + 1'b1) : '0;
        // fires on the edge where hc reaches LONG_CYCLES, gated by the level that will hold after it
        lp[i] <= state[i] && state_n[i] && hc[i] == HC_PRE;
      end
    end
  end
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RC_MAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rc [N];
  // rc is zero in the long_pulse cycle and then counts modulo REPEAT_CYCLES while held
  always_ff @(posedge clk) begin
    if (rst) begin
      rp <= '0;
      for (int i = 0; i < N; i++) rc[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        rc[i] <= (state_n[i] && hc[i] == HC_MAX && rc[i] != RC_MAX) ? rc[i] + 1'b1 : '0;
        rp[i] <= state_n[i] && hc[i] == HC_MAX && rc[i] == RC_MAX;
      end
    end
  end
`else
  assign rp = '0;
`endif
  assign bus.state = state;
  assign bus.press_pulse = state & ~prev;
  assign bus.depress_pulse = ~state & prev;
  assign bus.long_pulse = lp;
  assign bus.repeat_pulse = rp;
endmodule
